// File: rtl/blk_intlv_pingpong.sv
// rtl/blk_intlv_pingpong.sv - ping-pong block interleaver/deinterleaver
// Linear writes into one bank while the other bank drains in transposed order.
module blk_intlv_pingpong #(
  parameter int DATA_W = 8,
  parameter int ROWS = 4,
  parameter int COLS = 255,
  localparam int N = ROWS * COLS,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic              clk_out125M,
  input  logic              sys_rst,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              err_sof
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
  typedef enum logic {R_IDLE, R_RUN} rd_state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(COLS - 1);

  logic [DATA_W-1:0] mem [2][N];
  bank_state_t       bstate [2];
  logic              bmode [2];

  logic              wbank;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] waddr;
  logic              accept;
  logic              restart;

  rd_state_t         rstate, rstate_nx;
  logic              rbank, fbank, rmode;
  logic [ADDR_W-1:0] ri, ro, raddr, stride;
  logic              claim, claim_bank, issue;
  logic              i_last, o_last, blk_last;

  logic              rd_valid, rd_sof, rd_eof;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] q_data [3];
  logic              q_sof [3];
  logic              q_eof [3];
  logic [1:0]        q_cnt, q_wi;
  logic              pop, push;
  logic              err_q;

  assign s_ready = !sys_rst && (bstate[wbank] == B_EMPTY || bstate[wbank] == B_FILLING);
  assign accept  = s_valid && s_ready;
  assign restart = s_sof && (wcnt != '0);
  assign waddr   = restart ? '0 : wcnt;

  assign i_last   = rmode ? (ri == C_LAST) : (ri == R_LAST);
  assign o_last   = rmode ? (ro == R_LAST) : (ro == C_LAST);
  assign stride   = rmode ? ROWS_A : COLS_A;
  assign blk_last = i_last && o_last;

  assign m_valid = (q_cnt != 2'd0);
  assign m_data  = q_data[0];
  assign m_sof   = m_valid && q_sof[0];
  assign m_eof   = m_valid && q_eof[0];
  assign err_sof = err_q;
  assign pop     = m_valid && m_ready;
  assign push    = rd_valid;
  assign q_wi    = q_cnt - {1'b0, pop};

  always_ff @(posedge clk_out125M) begin
    if (accept) mem[wbank][waddr] <= s_data;
    if (issue) rd_data <= mem[rbank][raddr];
  end

  always_ff @(posedge clk_out125M) begin
    if (sys_rst) rstate <= R_IDLE;
    else         rstate <= rstate_nx;
  end

  // Reads are throttled so the output register plus skid can always absorb what is in flight.
  always_comb begin
    rstate_nx  = rstate;
    claim      = 1'b0;
    claim_bank = rbank;
    issue      = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (bstate[rbank] == B_FULL) begin
          claim     = 1'b1;
          rstate_nx = R_RUN;
        end
      end
      R_RUN: begin
        issue = ({1'b0, q_cnt} + {2'b0, rd_valid}) < 3'd3;
        if (issue && blk_last) begin
          claim_bank = ~rbank;
          if (bstate[~rbank] == B_FULL) claim = 1'b1;
          else                          rstate_nx = R_IDLE;
        end
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_out125M) begin
    if (sys_rst) begin
      bstate[0] <= B_EMPTY;
      bstate[1] <= B_EMPTY;
      bmode[0]  <= 1'b0;
      bmode[1]  <= 1'b0;
      wbank     <= 1'b0;
      wcnt      <= '0;
      rbank     <= 1'b0;
      fbank     <= 1'b0;
      rmode     <= 1'b0;
      ri        <= '0;
      ro        <= '0;
      raddr     <= '0;
      rd_valid  <= 1'b0;
      rd_sof    <= 1'b0;
      rd_eof    <= 1'b0;
      q_cnt     <= 2'd0;
      err_q     <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        q_data[k] <= '0;
        q_sof[k]  <= 1'b0;
        q_eof[k]  <= 1'b0;
      end
    end else begin
      err_q <= accept && restart;

      if (accept) begin
        if (restart) begin
          wcnt         <= ADDR_W'(1);
          bmode[wbank] <= mode;
        end else if (wcnt == LAST_A) begin
          wcnt          <= '0;
          wbank         <= ~wbank;
          bstate[wbank] <= B_FULL;
        end else begin
          if (wcnt == '0) begin
            bstate[wbank] <= B_FILLING;
            bmode[wbank]  <= mode;
          end
          wcnt <= wcnt + ADDR_W'(1);
        end
      end

      // Running-sum address: +stride per inner step, restart at the next column/row on wrap.
      if (issue) begin
        if (i_last) begin
          ri    <= '0;
          ro    <= ro + ADDR_W'(1);
          raddr <= ro + ADDR_W'(1);
        end else begin
          ri    <= ri + ADDR_W'(1);
          raddr <= raddr + stride;
        end
        if (blk_last) rbank <= ~rbank;
      end

      if (claim) begin
        bstate[claim_bank] <= B_DRAINING;
        rmode              <= bmode[claim_bank];
        ri                 <= '0;
        ro                 <= '0;
        raddr              <= '0;
      end

      rd_valid <= issue;
      rd_sof   <= issue && (ri == '0) && (ro == '0);
      rd_eof   <= issue && blk_last;

      if (pop) begin
        q_data[0] <= q_data[1];
        q_data[1] <= q_data[2];
        q_sof[0]  <= q_sof[1];
        q_sof[1]  <= q_sof[2];
        q_eof[0]  <= q_eof[1];
        q_eof[1]  <= q_eof[2];
      end
      if (push) begin
        q_data[q_wi] <= rd_data;
        q_sof[q_wi]  <= rd_sof;
        q_eof[q_wi]  <= rd_eof;
      end
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};

      // Banks are freed in the order they were drained.
      if (pop && q_eof[0]) begin
        bstate[fbank] <= B_EMPTY;
        fbank         <= ~fbank;
      end
    end
  end

endmodule

// File: tb/tb_blk_intlv_pingpong.sv
// tb/tb_blk_intlv_pingpong.sv - bench for blk_intlv_pingpong
// Two instances (3x5 and 4x255) share stimulus; sel picks the active one.
module tb_blk_intlv_pingpong;

  localparam int RS = 3, CS = 5, RL = 4, CL = 255, NL = 1020;

  logic clk = 1'b0;
  logic sys_rst, mode, s_valid, s_sof, m_ready, sel;
  logic [7:0] s_data;
  logic sr_s, mv_s, ms_s, me_s, er_s, sr_l, mv_l, ms_l, me_l, er_l;
  logic [7:0] md_s, md_l;
  logic sr, mv, msof, meof, err;
  logic [7:0] mdat;

  assign sr   = sel ? sr_l : sr_s;
  assign mv   = sel ? mv_l : mv_s;
  assign msof = sel ? ms_l : ms_s;
  assign meof = sel ? me_l : me_s;
  assign err  = sel ? er_l : er_s;
  assign mdat = sel ? md_l : md_s;

  blk_intlv_pingpong #(.DATA_W(8), .ROWS(RS), .COLS(CS)) dut_s (
    .clk_out125M(clk), .sys_rst(sys_rst), .mode(mode),
    .s_valid(s_valid && !sel), .s_ready(sr_s), .s_data(s_data), .s_sof(s_sof),
    .m_valid(mv_s), .m_ready(m_ready), .m_data(md_s), .m_sof(ms_s), .m_eof(me_s),
    .err_sof(er_s));

  blk_intlv_pingpong dut_l (
    .clk_out125M(clk), .sys_rst(sys_rst), .mode(mode),
    .s_valid(s_valid && sel), .s_ready(sr_l), .s_data(s_data), .s_sof(s_sof),
    .m_valid(mv_l), .m_ready(m_ready), .m_data(md_l), .m_sof(ms_l), .m_eof(me_l),
    .err_sof(er_l));

  int total = 0, bad = 0, cyc = 0, rdy_mode = 1;
  int occ = 0, beats = 0, last_beat = -10, last_acc = 0;

  typedef struct packed { logic [7:0] d; logic sof; logic eof; } beat_t;
  beat_t exp_q[$];
  logic [7:0] cur_q[$];
  logic [7:0] cap_q[$];
  logic cur_mode = 1'b0;
  logic err_pend = 1'b0;

  typedef struct packed { logic md; logic [14:0][7:0] din; logic [14:0][7:0] dout; } vec_t;
  vec_t vecs [3];
  int e_il [15] = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 9, 14};
  int e_di [15] = '{0, 3, 6, 9, 12, 1, 4, 7, 10, 13, 2, 5, 8, 11, 14};

  initial forever #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model: assemble blocks from accepted symbols, emit the transposed beat order.
  always @(negedge clk) begin
    int r, c, n, idx;
    r = sel ? RL : RS;
    c = sel ? CL : CS;
    n = r * c;
    if (sys_rst) begin
      check("s_ready_in_reset", sr, 0);
      exp_q.delete(); cur_q.delete(); occ = 0; err_pend = 1'b0;
    end else begin
      check("s_ready", sr, occ < 2);
      check("err_sof", err, err_pend);
      err_pend = 1'b0;
      if (mv && exp_q.size() == 0) check("valid_no_data", mv, 0);
      else if (mv && m_ready) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {mdat, msof, meof}, {e.d, e.sof, e.eof});
        if (rdy_mode == 1 && !msof) check("no_gap", cyc - last_beat, 1);
        last_beat = cyc;
        beats++;
        cap_q.push_back(mdat);
        if (meof) occ--;
      end
      if (s_valid && sr) begin
        if (s_sof && cur_q.size() != 0) begin
          cur_q.delete();
          err_pend = 1'b1;
        end
        if (cur_q.size() == 0) cur_mode = mode;
        cur_q.push_back(s_data);
        if (cur_q.size() == n) begin
          for (int j = 0; j < n; j++) begin
            idx = cur_mode ? (j % c) * r + j / c : (j % r) * c + j / r;
            exp_q.push_back('{cur_q[idx], j == 0, j == n - 1});
          end
          cur_q.delete();
          occ++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic sof, input logic md, input int idle);
    int n;
    repeat (idle) begin @(posedge clk); #1; end
    s_valid = 1'b1; s_data = d; s_sof = sof; mode = md;
    n = 0;
    @(negedge clk);
    while (!sr && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check("send_timeout", n, 0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while ((occ != 0 || exp_q.size() != 0) && n < lim) begin @(negedge clk); n++; end
    check("drain_timeout", n < lim, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, b0, vcnt;
    logic md;
    sel = 1'b0; sys_rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; mode = 1'b0;
    for (int k = 0; k < 15; k++) begin
      vecs[0].din[k] = 8'(k);       vecs[0].dout[k] = 8'(e_il[k]);
      vecs[1].din[k] = 8'(k);       vecs[1].dout[k] = 8'(e_di[k]);
      vecs[2].din[k] = 8'(e_il[k]); vecs[2].dout[k] = 8'(k);
    end
    vecs[0].md = 1'b0; vecs[1].md = 1'b1; vecs[2].md = 1'b1;

    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", {mv_s, mv_l}, 0);
    check("rst_m_data", {md_s, md_l}, 0);
    check("rst_sof_eof", {ms_s, me_s, ms_l, me_l}, 0);
    check("rst_err", {er_s, er_l}, 0);
    check("rst_s_ready", {sr_s, sr_l}, 2'b11);
    @(posedge clk); #1;

    // Table vectors on the 3x5 instance
    for (int v = 0; v < 3; v++) begin
      cap_q.delete();
      for (int k = 0; k < 15; k++) send(vecs[v].din[k], k == 0, vecs[v].md, 0);
      if (v == 0) begin
        b0 = last_acc;
        n = 0;
        while (!mv && n < 20) begin @(negedge clk); n++; end
        check("latency", cyc - b0, 3);
      end
      wait_drain(200);
      check("vec_count", cap_q.size(), 15);
      for (int k = 0; k < 15; k++)
        if (k < cap_q.size()) check("vec_data", cap_q[k], vecs[v].dout[k]);
    end

    // Mid-block s_sof restart at wcnt=7
    b0 = beats;
    for (int k = 0; k < 7; k++) send(8'(100 + k), k == 0, 1'b0, 0);
    send(8'd200, 1'b1, 1'b0, 0);
    @(negedge clk); check("err_pulse_hi", err, 1);
    @(negedge clk); check("err_pulse_lo", err, 0);
    @(posedge clk); #1;
    for (int k = 1; k < 15; k++) send(8'(200 + k), 1'b0, 1'b1, 0);
    wait_drain(200);
    check("restart_beats", beats - b0, 15);

    // Random traffic, random backpressure, mode toggled mid-block
    rdy_mode = 2;
    b0 = beats;
    for (int b = 0; b < 5; b++) begin
      md = 1'($urandom_range(0, 1));
      for (int k = 0; k < 15; k++)
        send(8'($urandom), (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
             (k == 0) ? md : 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    wait_drain(3000);
    rdy_mode = 1;
    check("random_beats", beats - b0, 75);

    // Three back-to-back default-size blocks
    sel = 1'b1;
    cap_q.delete();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < NL; k++) send(8'((k & 255) + b), k == 0, 1'b0, 0);
    wait_drain(5000);
    check("b2b_count", cap_q.size(), 3 * NL);
    if (cap_q.size() > 4) begin
      check("b2b_beat1", cap_q[1], 255);
      check("b2b_beat4", cap_q[4], 1);
    end

    // Reset during drain at beat 500
    for (int k = 0; k < NL; k++) send(8'($urandom), k == 0, 1'b1, 0);
    b0 = beats;
    n = 0;
    while (beats - b0 < 500 && n < 3000) begin @(negedge clk); n++; end
    check("reach_beat500", beats - b0, 500);
    @(posedge clk); #1 sys_rst = 1'b1;
    @(posedge clk); #1 sys_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {mv, msof, meof, err}, 0);
    check("mid_rst_data", mdat, 0);
    vcnt = 0;
    repeat (20) begin @(negedge clk); if (mv) vcnt++; end
    check("no_valid_after_rst", vcnt, 0);
    @(posedge clk); #1;
    b0 = beats;
    for (int k = 0; k < NL; k++) send(8'($urandom), k == 0, 1'b0, 0);
    wait_drain(3000);
    check("post_rst_beats", beats - b0, NL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blk_intlv_pingpong.md
Name: blk_intlv_pingpong

Overview:
Parametrised block interleaver/deinterleaver with ping-pong buffering. It is the successor to the fixed 4x255 symbol interleaver in the RS decoder chain. It accepts RS code symbols on a valid/ready stream and writes each block of ROWS*COLS symbols linearly into one of two RAM banks. It reads the other bank out in transposed order, with a per-block mode select for interleave or deinterleave, backpressure on both sides and block framing markers.

Parameters:
DATA_W, 8, symbol width in bits
ROWS, 4, interleave depth (number of codewords per block)
COLS, 255, symbols per codeword
ADDR_W, $clog2(ROWS*COLS), bank address width (derived, not overridable)

Ports:
clk_out125M  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
mode  in  1  0 = interleave, 1 = deinterleave; sampled with the first accepted symbol of each block
s_valid  in  1  input symbol valid
s_ready  out  1  input symbol accepted when s_valid&&s_ready
s_data  in  DATA_W  input symbol
s_sof  in  1  marks first symbol of a block
m_valid  out  1  output symbol valid
m_ready  in  1  downstream accepts output
m_data  out  DATA_W  output symbol
m_sof  out  1  first output symbol of a block
m_eof  out  1  last output symbol of a block
err_sof  out  1  one-cycle pulse: s_sof seen mid-block, partial block dropped

Behaviour:
- Reset (sys_rst=1 at a clock edge): both banks EMPTY, write and read counters 0, write bank = 0, s_ready=0 during reset. m_valid, m_sof, m_eof, err_sof and m_data all = 0. Reset mid-block discards all buffered data. No output beat is emitted after reset until a new full block is written.
- Bank state per bank: EMPTY -> FILLING (first accept) -> FULL (last accept, wcnt=ROWS*COLS-1) -> DRAINING (read side claims it) -> EMPTY (last output beat handshaken).
- Write side: s_ready=1 iff the current write bank is EMPTY or FILLING. Write address = wcnt, incremented per accept. At wcnt=N-1 (N=ROWS*COLS), wcnt returns to 0 and the write bank toggles. The captured mode is stored per bank.
- s_sof on an accept with wcnt!=0: partial block is discarded, that symbol is written at address 0, wcnt=1, err_sof pulses next cycle. s_sof is optional at wcnt=0.
- Read addressing uses nested counters with no multiplier. The inner counter i steps by stride S; the outer counter o steps by 1.
  - Interleave: inner limit ROWS, S=COLS, outer limit COLS; addr = i*COLS+o.
  - Deinterleave: inner limit COLS, S=ROWS, outer limit ROWS; addr = i*ROWS+o.
  - The address is maintained as a running sum: +S on inner step; o+1 on inner wrap.
- Read pipeline: 1-cycle RAM read, then an output register plus a 2-entry skid buffer. The address advances only when the skid is not full, so there is no data loss under any m_ready pattern.
- Latency: if the read side is idle and m_ready=1, the block's last input accept at edge T gives the first m_valid=1 after edge T+3.
- Throughput is 1 beat/cycle while m_ready=1. Back-to-back blocks stream with no gap on either side.
- Simultaneous write into bank A and read from bank B are independent. If both banks are FULL/DRAINING, s_ready=0 until a bank returns to EMPTY. The freed bank is writable on the cycle after its last output handshake.
- m_sof=1 with beat 0 of each block; m_eof=1 with beat N-1. Both are held stable with m_data while m_valid&&!m_ready.
- Mode change mid-block has no effect until the next block. Each bank drains in its own captured mode.

Test Plan:
1. ROWS=3, COLS=5, mode=0: input 0..14 continuous, m_ready=1 -> output 0,5,10,1,6,11,2,7,12,3,8,13,4,9,14. m_sof on 0, m_eof on 14, first m_valid 3 cycles after the last accept.
2. ROWS=3, COLS=5, mode=1: input 0..14 -> output 0,3,6,9,12,1,4,7,10,13,2,5,8,11,14. Then feed the case-1 output stream in mode=1 -> 0..14 restored.
3. Defaults (4x255), three back-to-back blocks with data=k[7:0]+block#, m_ready=1 -> s_ready never drops, 3060 output beats with no gaps, block 0 beat 1 = 255, beat 4 = 1.
4. Random m_ready (50%) and random s_valid over 5 blocks -> output matches the reference model exactly. s_ready=0 whenever both banks are occupied. No beat is dropped or duplicated.
5. s_sof asserted at wcnt=7 -> err_sof pulses one cycle. The block restarts from that symbol, and the output contains only the new block's N symbols.
6. sys_rst=1 for 1 cycle during a drain at beat 500 -> all outputs are 0 next cycle. No m_valid appears until a fresh full block is written. A following block is output correctly.
